// File: rtl/uart_rx_pkt_ctrl_pkg.sv
// rtl/uart_rx_pkt_ctrl_pkg.sv - shared states, baud table and defaults for the packet controller
package uart_rx_pkt_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LEN     = 2'd1,
      ST_PAYLOAD = 2'd2,
      ST_CSUM    = 2'd3
   } state_e;

   localparam logic [7:0]  DEFAULT_SYNC_BYTE = 8'hA5;

   localparam logic [11:0] CLKS_BAUD_0 = 12'd87;
   localparam logic [11:0] CLKS_BAUD_1 = 12'd174;
   localparam logic [11:0] CLKS_BAUD_2 = 12'd347;
   localparam logic [11:0] CLKS_BAUD_3 = 12'd1042;

   // Maps the 2-bit baud select onto a bit period in clocks
   function automatic logic [11:0] baud_clks(input logic [1:0] sel);
      case (sel)
         2'd0:    return CLKS_BAUD_0;
         2'd1:    return CLKS_BAUD_1;
         2'd2:    return CLKS_BAUD_2;
         default: return CLKS_BAUD_3;
      endcase
   endfunction

endpackage

// File: rtl/uart_rx_pkt_ctrl_if.sv
// rtl/uart_rx_pkt_ctrl_if.sv - receiver/FIFO side signals of the packet controller
interface uart_rx_pkt_ctrl_if;

   logic [1:0]  i_Baud_Sel;
   logic        i_Rx_DV;
   logic [7:0]  i_Rx_Byte;
   logic        i_Fifo_Full;
   logic [11:0] o_Clks_Per_Bit;
   logic        o_Fifo_Wr_En;
   logic [7:0]  o_Fifo_Wr_Data;
   logic        o_Pkt_Done;
   logic        o_Frame_Err;
   logic        o_Overflow;

   // Environment side: feeds bytes and FIFO status, observes results
   modport master (
      output i_Baud_Sel, i_Rx_DV, i_Rx_Byte, i_Fifo_Full,
      input  o_Clks_Per_Bit, o_Fifo_Wr_En, o_Fifo_Wr_Data, o_Pkt_Done, o_Frame_Err, o_Overflow
   );

   // Controller side
   modport slave (
      input  i_Baud_Sel, i_Rx_DV, i_Rx_Byte, i_Fifo_Full,
      output o_Clks_Per_Bit, o_Fifo_Wr_En, o_Fifo_Wr_Data, o_Pkt_Done, o_Frame_Err, o_Overflow
   );

endinterface

// File: rtl/uart_bit_timeout.sv
// rtl/uart_bit_timeout.sv - inter-byte timeout counted in bit periods
module uart_bit_timeout #(
   parameter int TIMEOUT_BITS = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        enable,
   input  logic [11:0] period,
   output logic        expire
);

   localparam int             BW    = $clog2(TIMEOUT_BITS + 1);
   localparam logic [BW-1:0]  LIMIT = BW'(TIMEOUT_BITS);

   logic [11:0]   tick_q, tick_d;
   logic [BW-1:0] bit_q, bit_d;
   logic          tick_wrap;

   // Tick counter wraps once per bit period; bit counter saturates at the limit
   always_comb begin
      tick_d    = tick_q;
      bit_d     = bit_q;
      tick_wrap = (tick_q == period - 12'd1);
      if (clear) begin
         tick_d = '0;
         bit_d  = '0;
      end else if (enable) begin
         tick_d = tick_wrap ? 12'd0 : tick_q + 12'd1;
         if (tick_wrap && (bit_q != LIMIT)) begin
            bit_d = bit_q + BW'(1);
         end
      end
   end

   // Counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_q <= '0;
         bit_q  <= '0;
      end else begin
         tick_q <= tick_d;
         bit_q  <= bit_d;
      end
   end

   assign expire = enable && (bit_q == LIMIT);

endmodule

// File: rtl/uart_rx_pkt_ctrl.sv
// rtl/uart_rx_pkt_ctrl.sv - sync/length/payload/checksum packet parser feeding a FIFO
module uart_rx_pkt_ctrl
   import uart_rx_pkt_ctrl_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE,
   parameter int         TIMEOUT_BITS = 32
) (
   input logic               i_Clock,
   input logic               i_Rst_n,
   uart_rx_pkt_ctrl_if.slave bus
);

   state_e      state_q, state_d;
   logic [7:0]  count_q, count_d;
   logic [7:0]  acc_q, acc_d;
   logic [11:0] clks_q, clks_d;
   logic        wr_en_q, wr_en_d;
   logic [7:0]  wr_data_q, wr_data_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic        ovf_q, ovf_d;
   logic        timer_clear;
   logic        timer_en;
   logic        expire;

   // Timer only runs mid-packet and restarts on every received byte
   assign timer_clear = bus.i_Rx_DV || (state_q == ST_IDLE);
   assign timer_en    = (state_q != ST_IDLE);

   uart_bit_timeout #(
      .TIMEOUT_BITS (TIMEOUT_BITS)
   ) u_timeout (
      .clk    (i_Clock),
      .rst_n  (i_Rst_n),
      .clear  (timer_clear),
      .enable (timer_en),
      .period (clks_q),
      .expire (expire)
   );

   // Next-state and output decode; a byte arriving together with expiry wins
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      acc_d     = acc_q;
      clks_d    = clks_q;
      wr_en_d   = 1'b0;
      wr_data_d = wr_data_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      ovf_d     = ovf_q;
      if (state_q == ST_IDLE) begin
         clks_d = baud_clks(bus.i_Baud_Sel);
      end
      if ((state_q != ST_IDLE) && !bus.i_Rx_DV && expire) begin
         err_d   = 1'b1;
         state_d = ST_IDLE;
      end else if (bus.i_Rx_DV) begin
         case (state_q)
            ST_IDLE: begin
               if (bus.i_Rx_Byte == SYNC_BYTE) begin
                  state_d = ST_LEN;
                  ovf_d   = 1'b0;
               end
            end
            ST_LEN: begin
               if (bus.i_Rx_Byte == 8'd0) begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  count_d = bus.i_Rx_Byte;
                  acc_d   = 8'd0;
                  state_d = ST_PAYLOAD;
               end
            end
            ST_PAYLOAD: begin
               acc_d   = acc_q ^ bus.i_Rx_Byte;
               count_d = count_q - 8'd1;
               if (bus.i_Fifo_Full) begin
                  ovf_d = 1'b1;
               end else begin
                  wr_en_d   = 1'b1;
                  wr_data_d = bus.i_Rx_Byte;
               end
               if (count_q == 8'd1) begin
                  state_d = ST_CSUM;
               end
            end
            default: begin
               if (bus.i_Rx_Byte == acc_q) begin
                  done_d = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State, datapath and registered outputs
   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state_q   <= ST_IDLE;
         count_q   <= '0;
         acc_q     <= '0;
         clks_q    <= CLKS_BAUD_0;
         wr_en_q   <= 1'b0;
         wr_data_q <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         acc_q     <= acc_d;
         clks_q    <= clks_d;
         wr_en_q   <= wr_en_d;
         wr_data_q <= wr_data_d;
         done_q    <= done_d;
         err_q     <= err_d;
         ovf_q     <= ovf_d;
      end
   end

   assign bus.o_Clks_Per_Bit = clks_q;
   assign bus.o_Fifo_Wr_En   = wr_en_q;
   assign bus.o_Fifo_Wr_Data = wr_data_q;
   assign bus.o_Pkt_Done     = done_q;
   assign bus.o_Frame_Err    = err_q;
   assign bus.o_Overflow     = ovf_q;

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// tb/tb_uart_rx_pkt_ctrl.sv - self-checking bench for the UART packet controller
module tb_uart_rx_pkt_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   uart_rx_pkt_ctrl_if bus ();

   uart_rx_pkt_ctrl #(
      .SYNC_BYTE    (8'hA5),
      .TIMEOUT_BITS (32)
   ) dut (
      .i_Clock (clk),
      .i_Rst_n (rst_n),
      .bus     (bus)
   );

   // Observed FIFO writes and pulse counts
   logic [7:0] wr_log[$];
   int         done_cnt = 0;
   int         err_cnt  = 0;
   int         viol_cnt = 0;
   logic       prev_wr = 1'b0, prev_done = 1'b0, prev_err = 1'b0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.o_Fifo_Wr_En) wr_log.push_back(bus.o_Fifo_Wr_Data);
         if (bus.o_Pkt_Done) done_cnt <= done_cnt + 1;
         if (bus.o_Frame_Err) err_cnt <= err_cnt + 1;
         if ((bus.o_Fifo_Wr_En && prev_wr) || (bus.o_Pkt_Done && prev_done) ||
             (bus.o_Frame_Err && prev_err)) viol_cnt <= viol_cnt + 1;
      end
      prev_wr   <= bus.o_Fifo_Wr_En;
      prev_done <= bus.o_Pkt_Done;
      prev_err  <= bus.o_Frame_Err;
   end

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_wr[$];
   int         wr_base, done_base, err_base, viol_base;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic full, input int gap);
      @(negedge clk);
      bus.i_Rx_DV     = 1'b1;
      bus.i_Rx_Byte   = b;
      bus.i_Fifo_Full = full;
      @(negedge clk);
      bus.i_Rx_DV     = 1'b0;
      bus.i_Fifo_Full = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic begin_pkt();
      wr_base   = wr_log.size();
      done_base = done_cnt;
      err_base  = err_cnt;
      viol_base = viol_cnt;
      exp_wr.delete();
   endtask

   task automatic end_pkt(input string name, input int exp_done, input int exp_err, input logic exp_ovf);
      int got;
      repeat (3) @(negedge clk);
      #1;
      got = wr_log.size() - wr_base;
      check({name, " wr_count"}, got, exp_wr.size());
      for (int i = 0; i < exp_wr.size() && i < got; i++)
         check($sformatf("%s wr_data[%0d]", name, i), wr_log[wr_base + i], exp_wr[i]);
      check({name, " pkt_done"}, done_cnt - done_base, exp_done);
      check({name, " frame_err"}, err_cnt - err_base, exp_err);
      check({name, " overflow"}, bus.o_Overflow, exp_ovf);
      check({name, " pulse_width"}, viol_cnt - viol_base, 0);
   endtask

   typedef struct {
      string       name;
      int          n;
      logic [63:0] bytes;      // byte 0 in the top octet
      logic [7:0]  full_mask;  // bit i = FIFO full while byte i is presented
      int          n_wr;
      logic [31:0] wr;         // expected write 0 in the top octet
      int          done;
      int          err;
      logic        ovf;
   } vec_t;

   vec_t vecs[8];

   initial begin
      vec_t       v;
      int         n, nj;
      logic [7:0] b, cs, junk;
      logic       full, ovf, bad;

      vecs[0] = '{"good3",     6, 64'hA5_03_11_22_33_00_00_00, 8'h00, 3, 32'h11_22_33_00, 1, 0, 1'b0};
      vecs[1] = '{"bad_csum",  5, 64'hA5_02_0F_F0_00_00_00_00, 8'h00, 2, 32'h0F_F0_00_00, 0, 1, 1'b0};
      vecs[2] = '{"zero_len",  2, 64'hA5_00_00_00_00_00_00_00, 8'h00, 0, 32'h0,           0, 1, 1'b0};
      vecs[3] = '{"overflow",  5, 64'hA5_02_AA_55_FF_00_00_00, 8'h04, 1, 32'h55_00_00_00, 1, 0, 1'b1};
      vecs[4] = '{"ovf_clear", 5, 64'h3C_A5_01_7E_7E_00_00_00, 8'h00, 1, 32'h7E_00_00_00, 1, 0, 1'b0};
      vecs[5] = '{"zero_data", 4, 64'hA5_01_00_00_00_00_00_00, 8'h00, 1, 32'h00_00_00_00, 1, 0, 1'b0};
      vecs[6] = '{"no_sync",   3, 64'h12_34_5A_00_00_00_00_00, 8'h00, 0, 32'h0,           0, 0, 1'b0};
      vecs[7] = '{"csum_err1", 4, 64'hA5_01_FF_00_00_00_00_00, 8'h00, 1, 32'hFF_00_00_00, 0, 1, 1'b0};

      // Reset state, with a non-default baud select that must not leak through
      bus.i_Baud_Sel  = 2'd3;
      bus.i_Rx_DV     = 1'b0;
      bus.i_Rx_Byte   = 8'h00;
      bus.i_Fifo_Full = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("rst wr_en", bus.o_Fifo_Wr_En, 0);
      check("rst wr_data", bus.o_Fifo_Wr_Data, 0);
      check("rst pkt_done", bus.o_Pkt_Done, 0);
      check("rst frame_err", bus.o_Frame_Err, 0);
      check("rst overflow", bus.o_Overflow, 0);
      check("rst clks", bus.o_Clks_Per_Bit, 87);
      bus.i_Baud_Sel = 2'd0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Directed vectors
      for (int k = 0; k < 8; k++) begin
         v = vecs[k];
         begin_pkt();
         for (int i = 0; i < v.n_wr; i++) exp_wr.push_back(v.wr[31 - 8*i -: 8]);
         for (int i = 0; i < v.n; i++) send_byte(v.bytes[63 - 8*i -: 8], v.full_mask[i], i % 3);
         end_pkt(v.name, v.done, v.err, v.ovf);
      end

      // Inter-byte timeout and mid-packet baud change
      begin_pkt();
      send_byte(8'hA5, 1'b0, 0);
      send_byte(8'h04, 1'b0, 0);
      send_byte(8'h01, 1'b0, 0);
      exp_wr.push_back(8'h01);
      bus.i_Baud_Sel = 2'd3;
      repeat (2780) @(negedge clk);
      #1;
      check("timeout early_err", err_cnt - err_base, 0);
      check("timeout clks_mid", bus.o_Clks_Per_Bit, 87);
      repeat (10) @(negedge clk);
      #1;
      check("timeout err", err_cnt - err_base, 1);
      check("timeout clks_idle", bus.o_Clks_Per_Bit, 1042);
      bus.i_Baud_Sel = 2'd0;
      end_pkt("timeout", 0, 1, 1'b0);
      check("timeout clks_back", bus.o_Clks_Per_Bit, 87);

      // Reset in the middle of a packet
      begin_pkt();
      send_byte(8'hA5, 1'b0, 0);
      send_byte(8'h05, 1'b0, 0);
      send_byte(8'h01, 1'b0, 0);
      exp_wr.push_back(8'h01);
      bus.i_Baud_Sel = 2'd2;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst wr_en", bus.o_Fifo_Wr_En, 0);
      check("midrst wr_data", bus.o_Fifo_Wr_Data, 0);
      check("midrst pulses", {bus.o_Pkt_Done, bus.o_Frame_Err, bus.o_Overflow}, 0);
      check("midrst clks", bus.o_Clks_Per_Bit, 87);
      repeat (2) @(negedge clk);
      bus.i_Baud_Sel = 2'd0;
      rst_n = 1'b1;
      send_byte(8'h02, 1'b0, 2);
      end_pkt("midrst", 0, 0, 1'b0);
      begin_pkt();
      send_byte(8'hA5, 1'b0, 0);
      send_byte(8'h01, 1'b0, 0);
      send_byte(8'h33, 1'b0, 0);
      send_byte(8'h33, 1'b0, 0);
      exp_wr.push_back(8'h33);
      end_pkt("after_rst", 1, 0, 1'b0);

      // Random packets against the packet-level model; the first one uses N=255
      for (int p = 0; p < 40; p++) begin
         n   = (p == 0) ? 255 : int'($urandom_range(1, 12));
         cs  = 8'h00;
         ovf = 1'b0;
         begin_pkt();
         nj = int'($urandom_range(0, 2));
         for (int j = 0; j < nj; j++) begin
            junk = 8'($urandom_range(0, 255));
            if (junk == 8'hA5) junk = 8'h5A;
            send_byte(junk, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
         end
         send_byte(8'hA5, 1'b0, int'($urandom_range(0, 3)));
         send_byte(8'(n), 1'b0, int'($urandom_range(0, 3)));
         for (int i = 0; i < n; i++) begin
            b    = 8'($urandom_range(0, 255));
            full = ($urandom_range(0, 3) == 0);
            cs   = cs ^ b;
            if (full) ovf = 1'b1;
            else exp_wr.push_back(b);
            send_byte(b, full, int'($urandom_range(0, 3)));
         end
         bad = ($urandom_range(0, 2) == 0);
         send_byte(bad ? (cs ^ 8'($urandom_range(1, 255))) : cs, 1'b0, 0);
         end_pkt($sformatf("rand%0d", p), bad ? 0 : 1, bad ? 1 : 0, ovf);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
